// File: rtl/seq_mul_add_n.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mul_add_n
//  Purpose  : Sequential sum-of-products engine (shift-add multiplier,
//             on-chip operand pairs, accumulate mode, sticky overflow).
//  Revision : 1.0
// ============================================================================
module seq_mul_add_n #(
    parameter int WIDTH  = 4,
    parameter int NPAIRS = 2,
    parameter int SELW   = 1,
    parameter int ACCW   = 9
) (
    input  logic                 clkP,
    input  logic                 resN,
    input  logic                 wrEn,
    input  logic [SELW-1:0]      wrSel,
    input  logic [2*WIDTH-1:0]   wrData,
    input  logic                 start,
    input  logic                 accMode,
    output logic [ACCW-1:0]      result,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int PW   = 2 * WIDTH;
    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [SELW:0]     c_npairs   = (SELW + 1)'(NPAIRS);
    localparam logic [SELW-1:0]   c_last_idx = SELW'(NPAIRS - 1);
    localparam logic [CNTW-1:0]   c_last_cnt = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_pair [NPAIRS];
    logic [SELW-1:0]    r_idx;
    logic [CNTW-1:0]    r_cnt;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_prod;
    logic [ACCW-1:0]    r_acc;

    logic [ACCW:0]      w_sum;
    logic [SELW-1:0]    w_next_idx;
    logic               w_sel_ok;

    // The extra top bit of the sum is the carry that feeds the sticky flag.
    assign w_sum      = {1'b0, r_acc} + (ACCW + 1)'(r_prod);
    assign w_next_idx = r_idx + 1'b1;
    assign w_sel_ok   = ({1'b0, wrSel} < c_npairs);

    always_ff @(posedge clkP or negedge resN) begin
        if (!resN) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            for (int i = 0; i < NPAIRS; i++) begin
                r_pair[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_mcand  <= PW'(r_pair[0][PW-1:WIDTH]);
                        r_mplier <= r_pair[0][WIDTH-1:0];
                        r_prod   <= '0;
                        r_acc    <= accMode ? result : '0;
                        if (!accMode) begin
                            ovf <= 1'b0;
                        end
                        busy     <= 1'b1;
                        r_state  <= S_MUL;
                    end else if (wrEn && !done && w_sel_ok) begin
                        // The completion-pulse cycle still refuses operand writes.
                        r_pair[wrSel] <= wrData;
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == c_last_cnt) begin
                        r_state <= S_ADD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ADD: begin
                    r_acc <= w_sum[ACCW-1:0];
                    if (w_sum[ACCW]) begin
                        ovf <= 1'b1;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx    <= w_next_idx;
                        r_cnt    <= '0;
                        r_mcand  <= PW'(r_pair[w_next_idx][PW-1:WIDTH]);
                        r_mplier <= r_pair[w_next_idx][WIDTH-1:0];
                        r_prod   <= '0;
                        r_state  <= S_MUL;
                    end
                end
                S_DONE: begin
                    result  <= r_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_add_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mul_add_n
//  Purpose  : Randomised self-checking bench for seq_mul_add_n, running a
//             2-pair/9-bit and a 3-pair/10-bit instance side by side.
//  Revision : 1.0
// ============================================================================
module tb_seq_mul_add_n;

    localparam int LAT2 = 2 * (4 + 1) + 1;
    localparam int LAT3 = 3 * (4 + 1) + 1;

    logic       clk = 1'b0;
    logic       res_n;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic       start;
    logic       acc_mode;

    logic       wr_en2;
    logic       wr_sel2;
    logic [8:0] result2;
    logic       busy2, done2, ovf2;
    logic [9:0] result3;
    logic       busy3, done3, ovf3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: index 0 is the 2-pair instance, index 1 the 3-pair one.
    int ma [2][3];
    int mb [2][3];
    int mres [2];
    bit movf [2];

    always #5 clk = ~clk;

    // The 2-pair instance has a 1-bit select, so indices 2 and 3 never reach it.
    assign wr_en2  = wr_en && (wr_sel < 2'd2);
    assign wr_sel2 = wr_sel[0];

    seq_mul_add_n #(.WIDTH(4), .NPAIRS(2), .SELW(1), .ACCW(9)) dut2 (
        .clkP(clk), .resN(res_n), .wrEn(wr_en2), .wrSel(wr_sel2),
        .wrData(wr_data), .start(start), .accMode(acc_mode),
        .result(result2), .busy(busy2), .done(done2), .ovf(ovf2)
    );

    seq_mul_add_n #(.WIDTH(4), .NPAIRS(3), .SELW(2), .ACCW(10)) dut3 (
        .clkP(clk), .resN(res_n), .wrEn(wr_en), .wrSel(wr_sel),
        .wrData(wr_data), .start(start), .accMode(acc_mode),
        .result(result3), .busy(busy3), .done(done3), .ovf(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int mac(input int d, input bit am, output bit ov);
        int n   = (d == 0) ? 2 : 3;
        int lim = (d == 0) ? 512 : 1024;
        int acc = am ? mres[d] : 0;
        ov = am ? movf[d] : 1'b0;
        for (int i = 0; i < n; i++) begin
            acc += ma[d][i] * mb[d][i];
            if (acc >= lim) begin
                acc -= lim;
                ov = 1'b1;
            end
        end
        return acc;
    endfunction

    task automatic do_write(input int sel, input int a, input int b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel[1:0];
        wr_data = {a[3:0], b[3:0]};
        @(negedge clk);
        wr_en = 1'b0;
        if (sel < 2) begin ma[0][sel] = a; mb[0][sel] = b; end
        if (sel < 3) begin ma[1][sel] = a; mb[1][sel] = b; end
    endtask

    // One operation; optionally inject a pair-1 write (and start) after edge inj_k,
    // or collide a pair-0 write with the accepting start.
    task automatic run_op(input bit am, input int inj_k, input bit inj_start, input bit collide);
        int exp [2];
        bit eov [2];
        int old [2];
        for (int d = 0; d < 2; d++) begin
            old[d] = mres[d];
            exp[d] = mac(d, am, eov[d]);
        end
        @(negedge clk);
        start    = 1'b1;
        acc_mode = am;
        if (collide) begin
            wr_en   = 1'b1;
            wr_sel  = 2'd0;
            wr_data = 8'h99;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k <= LAT3 + 1; k++) begin
            if (k > 0) @(negedge clk);
            check("busy2",   busy2,   (k < LAT2));
            check("done2",   done2,   (k == LAT2));
            check("result2", result2, (k >= LAT2) ? exp[0] : old[0]);
            if (k >= LAT2) check("ovf2", ovf2, eov[0]);
            check("busy3",   busy3,   (k < LAT3));
            check("done3",   done3,   (k == LAT3));
            check("result3", result3, (k >= LAT3) ? exp[1] : old[1]);
            if (k >= LAT3) check("ovf3", ovf3, eov[1]);
            if (k == inj_k) begin
                wr_en   = 1'b1;
                wr_sel  = 2'd1;
                wr_data = 8'hFF;
                start   = inj_start;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
        end
        wr_en = 1'b0;
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mres[d] = exp[d];
            movf[d] = eov[d];
        end
    endtask

    task automatic reset_mid(input bit am);
        @(negedge clk);
        start    = 1'b1;
        acc_mode = am;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("busy2_before_rst", busy2, 1'b1);
        #2 res_n = 1'b0;
        #1;
        check("rst_result2", result2, 0);
        check("rst_busy2",   busy2,   0);
        check("rst_ovf2",    ovf2,    0);
        check("rst_result3", result3, 0);
        check("rst_busy3",   busy3,   0);
        check("rst_ovf3",    ovf3,    0);
        #1 res_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mres[d] = 0;
            movf[d] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                ma[d][i] = 0;
                mb[d][i] = 0;
            end
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("no_done2", done2, 0);
            check("no_done3", done3, 0);
            check("idle_busy2", busy2, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        res_n    = 1'b0;
        wr_en    = 1'b0;
        wr_sel   = '0;
        wr_data  = '0;
        start    = 1'b0;
        acc_mode = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mres[d] = 0;
            movf[d] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                ma[d][i] = 0;
                mb[d][i] = 0;
            end
        end
        repeat (3) @(negedge clk);
        check("reset_result2", result2, 0);
        check("reset_busy2",   busy2,   0);
        check("reset_done2",   done2,   0);
        check("reset_ovf2",    ovf2,    0);
        check("reset_result3", result3, 0);
        check("reset_busy3",   busy3,   0);
        res_n = 1'b1;

        // Basic sum of products
        do_write(0, 3, 5);
        do_write(1, 7, 2);
        run_op(1'b0, -1, 1'b0, 1'b0);

        // Largest products, then accumulate with wrap, then fresh start
        do_write(0, 15, 15);
        do_write(1, 15, 15);
        run_op(1'b0, -1, 1'b0, 1'b0);
        run_op(1'b1, -1, 1'b0, 1'b0);
        run_op(1'b0, -1, 1'b0, 1'b0);

        // Writes and starts while busy, in DONE, and in the done-pulse cycle
        do_write(0, 3, 5);
        do_write(1, 7, 2);
        run_op(1'b0, 4,  1'b1, 1'b0);
        run_op(1'b0, 10, 1'b1, 1'b0);
        run_op(1'b0, 11, 1'b0, 1'b0);
        run_op(1'b0, -1, 1'b0, 1'b0);

        // Start/write collision, then out-of-range and last-pair writes
        run_op(1'b0, -1, 1'b0, 1'b1);
        do_write(3, 9, 9);
        run_op(1'b0, -1, 1'b0, 1'b0);
        do_write(2, 1, 1);
        run_op(1'b0, -1, 1'b0, 1'b0);

        // Overflowed accumulate, then reset in the middle of the next operation
        do_write(0, 15, 15);
        do_write(1, 15, 15);
        do_write(2, 15, 15);
        run_op(1'b0, -1, 1'b0, 1'b0);
        run_op(1'b1, -1, 1'b0, 1'b0);
        reset_mid(1'b1);
        run_op(1'b0, -1, 1'b0, 1'b0);

        // Random operand sets and modes
        for (int r = 0; r < 12; r++) begin
            int nw;
            nw = int'($urandom_range(1, 3));
            for (int w = 0; w < nw; w++) begin
                do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)));
            end
            run_op(1'($urandom_range(0, 1)), -1, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
